// File: rtl/image_memory_writer.sv
// Streams one frame of pixels into image memory at offset + y*IMAGE_WIDTH + x,
// mirroring the address layout used by the VGA read-side decoder.
module image_memory_writer #(
  parameter int          IMAGE_WIDTH      = 250,
  parameter int          IMAGE_HEIGHT     = 250,
  parameter logic [31:0] BASE_OFFSET      = 32'h0,
  parameter logic [31:0] ENCRYPTED_OFFSET = 32'h10000,
  parameter int          DATA_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  image_select,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] pixel_data,
  input  logic                  pixel_valid,
  output logic                  pixel_ready,
  output logic [31:0]           mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  done
);

  localparam int XW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            sel;
  logic            beat;
  logic            last_x;
  logic            last_y;
  logic [31:0]     offset;
  logic [31:0]     addr;

  // Handshake: a beat transfers on a rising edge where pixel_valid and
  // pixel_ready are both high; pixel_ready depends only on the state register.
  assign pixel_ready = (state == ST_WRITE);
  assign busy        = (state == ST_WRITE);
  assign done        = (state == ST_DONE);

  // A beat offered alongside abort is dropped, so it never reaches the RAM.
  assign beat   = (state == ST_WRITE) && pixel_valid && !abort;
  assign last_x = (x == XW'(IMAGE_WIDTH - 1));
  assign last_y = (y == YW'(IMAGE_HEIGHT - 1));
  assign offset = sel ? BASE_OFFSET : ENCRYPTED_OFFSET;
  assign addr   = offset + (32'(y) * 32'(IMAGE_WIDTH)) + 32'(x);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (abort)                          state_next = ST_IDLE;
        else if (beat && last_x && last_y)  state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      sel         <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
    end else begin
      mem_we <= beat;
      if ((state == ST_IDLE) && start) begin
        sel <= image_select;
        x   <= '0;
        y   <= '0;
      end
      if (beat) begin
        mem_address <= addr;
        mem_wdata   <= pixel_data;
        if (last_x) begin
          x <= '0;
          y <= y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

endmodule
